// File: rtl/count_pwm_gen.sv
// -----------------------------------------------------------------------------
// count_pwm_gen
//
// Purpose:
//   PWM generator that sits downstream of a free-running CNT_W-bit binary
//   counter. Each counter wrap is one PWM period of 2**CNT_W clocks. The count
//   is compared against a double-buffered duty value. New duty values arrive
//   through a valid/ready handshake into a shadow register. They are committed
//   to the active duty only at a period boundary, so every period is whole.
//
// Configuration macro:
//   PWM_COMP_EN - when defined, adds the complementary output pwm_n_out and
//                 dead-time insertion of DEAD_T cycles on both rising edges.
//                 When undefined, pwm_out is the registered compare result and
//                 DEAD_T has no effect.
//
// Parameters:
//   CNT_W   width of the consumed count; the period is 2**CNT_W cycles
//   DEAD_T  dead-time in clk cycles, 1..7 (used only with PWM_COMP_EN)
//
// Ports:
//   clk           rising-edge clock, shared with the upstream counter
//   reset         asynchronous, active-high reset
//   count         count value from the upstream counter
//   duty_in       requested high-time in cycles, 0..2**CNT_W (larger saturates)
//   duty_valid    duty_in is valid this cycle
//   duty_ready    shadow register is free; a handshake is valid && ready
//   period_start  one-cycle pulse in the first cycle after a period boundary
//   pwm_out       PWM output
//   pwm_n_out     complementary PWM output (PWM_COMP_EN only)
// -----------------------------------------------------------------------------
module count_pwm_gen #(
    parameter int CNT_W  = 4,
    parameter int DEAD_T = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             period_start,
`ifdef PWM_COMP_EN
    output logic             pwm_n_out,
`endif
    output logic             pwm_out
);

    // Full-period duty (2**CNT_W): the output stays high for every count.
    localparam logic [CNT_W:0] DUTY_MAX = {1'b1, {CNT_W{1'b0}}};

    // The dead-time counters are 3 bits wide, so the range is checked here
    // rather than failing silently by truncation.
    if (DEAD_T < 1 || DEAD_T > 7) begin : g_dead_t_range
        $error("count_pwm_gen: DEAD_T must be in 1..7");
    end

    typedef enum logic {
        EMPTY,
        PENDING
    } shadow_state_t;

    shadow_state_t    state;
    shadow_state_t    state_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W:0]   shadow;
    logic [CNT_W:0]   duty_active;
    logic [CNT_W:0]   duty_sat;
    logic [CNT_W:0]   duty_eff;
    logic             boundary;
    logic             load_shadow;
    logic             commit;
    logic             raw;

    // A boundary is the first zero after a non-zero count. This covers a
    // normal wrap and an upstream reset in mid-period. A count held at zero
    // produces no further boundaries.
    assign boundary    = (count == '0) && (count_q != '0);
    assign load_shadow = (state == EMPTY) && duty_valid;
    assign commit      = (state == PENDING) && boundary;
    assign duty_sat    = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;

    // The boundary cycle is already count 0 of the new period. The committed
    // value is bypassed to the compare so that it governs that very count.
    assign duty_eff    = commit ? shadow : duty_active;

    // Shadow-register FSM: state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    // Shadow-register FSM: next state and handshake output.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        duty_ready = 1'b0;
        case (state)
            EMPTY: begin
                duty_ready = 1'b1;
                if (duty_valid) state_next = PENDING;
            end
            PENDING: begin
                // duty_valid is ignored until the held value is committed.
                if (boundary) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Datapath: count history, boundary pulse, duty buffers, compare.
    // NOTE: the duty registers are plain flops, not a memory, so they take
    // the async reset like everything else and start at a defined zero duty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            period_start <= 1'b0;
            shadow       <= '0;
            duty_active  <= '0;
            raw          <= 1'b0;
        end else begin
            count_q      <= count;
            period_start <= boundary;
            if (load_shadow) shadow      <= duty_sat;
            if (commit)      duty_active <= shadow;
            // Compared at CNT_W+1 bits, so duty 2**CNT_W is true for all counts.
            raw          <= ({1'b0, count} < duty_eff);
        end
    end

`ifdef PWM_COMP_EN
    localparam logic [2:0] DEAD = 3'(DEAD_T);

    logic [2:0] on_cnt;
    logic [2:0] off_cnt;

    // Each output has its own down-counter. It is re-armed to DEAD while the
    // opposite phase is active and counts down while its own phase is active.
    // The output may assert only once its counter reaches zero. Reset arms
    // both counters, so both outputs come out of reset low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_cnt  <= DEAD;
            off_cnt <= DEAD;
        end else begin
            if (!raw)                on_cnt <= DEAD;
            else if (on_cnt != '0)   on_cnt <= on_cnt - 3'd1;

            if (raw)                 off_cnt <= DEAD;
            else if (off_cnt != '0)  off_cnt <= off_cnt - 3'd1;
        end
    end

    // Falling edges follow raw in the same cycle. Rising edges wait out the
    // dead time. Because raw gates both outputs, they can never overlap.
    assign pwm_out   =  raw && (on_cnt  == '0);
    assign pwm_n_out = !raw && (off_cnt == '0);
`else
    assign pwm_out = raw;
`endif

endmodule

// File: tb/tb_count_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_count_pwm_gen
//
// Purpose:
//   Directed self-checking bench for count_pwm_gen with CNT_W=4. A free-running
//   4-bit upstream counter is modelled here, with a synchronous reset that
//   the bench can pulse. Stimulus is one linear sequence of directed steps.
//   Each step is compared against hand-computed constants.
//   The sample_period task records one full period of outputs. It starts and
//   ends on the falling edge at which count==1. Sample i holds the response
//   to count i, because the output lags the count by one clock.
//
// Configuration macro:
//   PWM_COMP_EN - when defined, the expected waveforms account for a 2-cycle
//                 dead time, and the complementary-output checks are enabled.
// -----------------------------------------------------------------------------
module tb_count_pwm_gen;

`ifdef PWM_COMP_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       cnt_rst;
    logic [3:0] count;
    logic [4:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       period_start;
    logic       pwm_out;
    logic       pwm_n_out;

    int checks = 0;
    int errors = 0;

    count_pwm_gen #(
        .CNT_W  (4),
        .DEAD_T (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .count        (count),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .period_start (period_start),
`ifdef PWM_COMP_EN
        .pwm_n_out    (pwm_n_out),
`endif
        .pwm_out      (pwm_out)
    );

`ifndef PWM_COMP_EN
    assign pwm_n_out = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream free-running counter with a synchronous reset.
    always @(posedge clk) begin
        if (cnt_rst) count <= 4'd0;
        else         count <= count + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge where count==v, within a bounded budget.
    task automatic wait_cnt(input logic [3:0] v);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (count == v) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_count_reached", 32'(found), 32'd1);
    endtask

    // Record one period. Any duty write presented before the call is
    // dropped after its first clock edge.
    task automatic sample_period(output logic [15:0] pat, output logic [15:0] npat,
                                 output int ps);
        pat  = '0;
        npat = '0;
        ps   = 0;
        for (int i = 0; i < 16; i++) begin
            pat[i]  = pwm_out;
            npat[i] = pwm_n_out;
            ps      = ps + int'(period_start);
            @(negedge clk);
            duty_valid = 1'b0;
        end
    endtask

`ifdef PWM_COMP_EN
    always @(negedge clk) begin
        if (!reset) check("no_overlap", 32'(pwm_out && pwm_n_out), 32'd0);
    end
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat;
        logic [15:0] npat;
        int          ps;

        // T1: reset values take effect immediately (asynchronous reset).
        reset      = 1'b1;
        cnt_rst    = 1'b1;
        duty_in    = 5'd0;
        duty_valid = 1'b0;
        #2;
        check("t1_reset_pwm",   32'(pwm_out),      32'd0);
        check("t1_reset_ready", 32'(duty_ready),   32'd1);
        check("t1_reset_start", 32'(period_start), 32'd0);
        check("t1_reset_pwm_n", 32'(pwm_n_out),    32'd0);
        #8;
        reset   = 1'b0;
        cnt_rst = 1'b0;

        // With no duty loaded the output stays low. The count leaving zero
        // after reset release is not a boundary.
        wait_cnt(4'd1);
        sample_period(pat, npat, ps);
        check("t1_idle_pwm",        32'(pat), 32'h0000);
        check("t1_no_start_window", 32'(ps),  32'd0);
        check("t1_first_wrap",      32'(period_start), 32'd1);

        // T2: load duty 5. Ready drops and the value applies from the next wrap.
        duty_in    = 5'd5;
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        check("t2_ready_low", 32'(duty_ready), 32'd0);
        wait_cnt(4'd1);
        check("t2_ready_back", 32'(duty_ready),   32'd1);
        check("t2_start",      32'(period_start), 32'd1);
        sample_period(pat, npat, ps);
        check("t2_duty5",       32'(pat), COMP ? 32'h001C : 32'h001F);
        check("t2_start_once",  32'(ps),  32'd1);

        // T3: 3 is taken and 12 is ignored while pending; 12 applies after ready returns.
        duty_in    = 5'd3;
        duty_valid = 1'b1;
        @(negedge clk);
        check("t3_ready_low", 32'(duty_ready), 32'd0);
        duty_in = 5'd12;
        @(negedge clk);
        @(negedge clk);
        duty_valid = 1'b0;
        wait_cnt(4'd1);
        check("t3_ready_back", 32'(duty_ready), 32'd1);
        duty_in    = 5'd12;
        duty_valid = 1'b1;
        sample_period(pat, npat, ps);
        check("t3_duty3",  32'(pat), COMP ? 32'h0004 : 32'h0007);
        sample_period(pat, npat, ps);
        check("t3_duty12", 32'(pat), COMP ? 32'h0FFC : 32'h0FFF);

        // T4: 20 saturates to 16, which is high across the wrap. Then 0 is low.
        duty_in    = 5'd20;
        duty_valid = 1'b1;
        sample_period(pat, npat, ps);
        check("t4_still12", 32'(pat), COMP ? 32'h0FFC : 32'h0FFF);
        sample_period(pat, npat, ps);
        check("t4_sat_first", 32'(pat), COMP ? 32'hFFFC : 32'hFFFF);
        duty_in    = 5'd0;
        duty_valid = 1'b1;
        sample_period(pat, npat, ps);
        check("t4_sat_wrap", 32'(pat), 32'hFFFF);
        sample_period(pat, npat, ps);
        check("t4_duty0",    32'(pat), 32'h0000);

        // T5: a duty of 5 is pending. An upstream reset at count 9 is a
        // boundary, which commits it. Holding count at 0 adds no pulses.
        duty_in    = 5'd5;
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        wait_cnt(4'd9);
        cnt_rst = 1'b1;
        ps      = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ps = ps + int'(period_start);
        end
        check("t5_count_held",   32'(count),   32'd0);
        check("t5_start_once",   32'(ps),      32'd1);
        check("t5_pwm_committed", 32'(pwm_out), 32'd1);
        cnt_rst = 1'b0;
        @(negedge clk);
        sample_period(pat, npat, ps);
        check("t5_restart_wave", 32'(pat), 32'h001F);
        check("t5_no_extra",     32'(ps),  32'd0);

`ifdef PWM_COMP_EN
        // T6: duty 8 with a 2-cycle dead time gives 6 high cycles on each output.
        duty_in    = 5'd8;
        duty_valid = 1'b1;
        sample_period(pat, npat, ps);
        check("t6_prev_pwm",   32'(pat),  32'h001C);
        check("t6_prev_pwm_n", 32'(npat), 32'hFF80);
        sample_period(pat, npat, ps);
        check("t6_pwm",   32'(pat),  32'h00FC);
        check("t6_pwm_n", 32'(npat), 32'hFC00);
        sample_period(pat, npat, ps);
        check("t6_pwm_steady",   32'(pat),  32'h00FC);
        check("t6_pwm_n_steady", 32'(npat), 32'hFC00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
